// File: rtl/operadores_seq_arb.sv
// Two-channel round-robin arbiter + sequencer: concatenates operand low halves, replicates, shifts left 1 bit/clk.
// Latency: ack in cycle 1 after the grant edge, out_valid in cycle 2+shamt; one op per 3+shamt cycles.
// Backpressure: req/ack handshake; requests seen while busy wait in place and are sampled only at grant.
//
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   reqN/dataaN/databN/   channel N request, operands and shift amount
//   shamtN, ackN          ackN pulses for one cycle when channel N operands are captured
//   busy                  high whenever the sequencer is not idle
//   grant_id              channel owning the current (or most recent) operation
//   out_valid             one-cycle result strobe
//   out_cat/out_rep/      {A[H-1:0],B[H-1:0]}, three copies of it, and it shifted left by shamt
//   out_shl
module operadores_seq_arb #(
    parameter int W  = 6,
    parameter int SW = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0,
    input  logic [W-1:0]    dataa0,
    input  logic [W-1:0]    datab0,
    input  logic [SW-1:0]   shamt0,
    output logic            ack0,
    input  logic            req1,
    input  logic [W-1:0]    dataa1,
    input  logic [W-1:0]    datab1,
    input  logic [SW-1:0]   shamt1,
    output logic            ack1,
    output logic            busy,
    output logic            grant_id,
    output logic            out_valid,
    output logic [W-1:0]    out_cat,
    output logic [3*W-1:0]  out_rep,
    output logic [W-1:0]    out_shl
);

    localparam int H = W / 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;

    logic            r_last;
    logic            r_grant;
    logic [H-1:0]    r_a;
    logic [H-1:0]    r_b;
    logic [SW-1:0]   r_shamt;
    logic [SW-1:0]   r_cnt;
    logic [W-1:0]    r_work;

    logic            r_ack0;
    logic            r_ack1;
    logic            r_busy;
    logic            r_valid;
    logic [W-1:0]    r_cat;
    logic [3*W-1:0]  r_rep;
    logic [W-1:0]    r_shl;

    logic            w_take;
    logic            w_gnt;
    logic [W-1:0]    w_cat;
    logic [W-1:0]    w_work_nxt;

    // Only the low halves of the operands ever reach the datapath.
    logic            w_unused_hi;
    assign w_unused_hi = ^{dataa0[W-1:H], datab0[W-1:H], dataa1[W-1:H], datab1[W-1:H]};

    assign w_cat = {r_a, r_b};

    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        w_gnt       = 1'b0;
        w_work_nxt  = r_work;
        case (r_state)
            S_IDLE: begin
                if (req0 || req1) begin
                    w_take      = 1'b1;
                    w_state_nxt = S_LOAD;
                    // On a tie the channel that did not go last wins.
                    if (req0 && req1) w_gnt = ~r_last;
                    else              w_gnt = req1;
                end
            end
            S_LOAD: begin
                w_work_nxt  = w_cat;
                w_state_nxt = (r_shamt != '0) ? S_SHIFT : S_DONE;
            end
            S_SHIFT: begin
                w_work_nxt = r_work << 1;
                // cnt==1 means this is the last of the shamt shift cycles.
                if (r_cnt == SW'(1)) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_shamt <= '0;
            r_cnt   <= '0;
            r_work  <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_cat   <= '0;
            r_rep   <= '0;
            r_shl   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_work  <= w_work_nxt;
            // Status outputs are registered from the next state so they line up with it.
            r_busy  <= (w_state_nxt != S_IDLE);
            r_valid <= (w_state_nxt == S_DONE);
            r_ack0  <= w_take & ~w_gnt;
            r_ack1  <= w_take &  w_gnt;

            if (w_take) begin
                r_grant <= w_gnt;
                r_a     <= w_gnt ? dataa1[H-1:0] : dataa0[H-1:0];
                r_b     <= w_gnt ? datab1[H-1:0] : datab0[H-1:0];
                r_shamt <= w_gnt ? shamt1 : shamt0;
            end

            if (r_state == S_LOAD)  r_cnt <= r_shamt;
            if (r_state == S_SHIFT) r_cnt <= r_cnt - SW'(1);

            // Results are captured on entry to DONE so they are valid with the strobe.
            if (w_state_nxt == S_DONE) begin
                r_cat <= w_cat;
                r_rep <= {3{w_cat}};
                r_shl <= w_work_nxt;
            end

            if (r_state == S_DONE) r_last <= r_grant;
        end
    end

    assign ack0      = r_ack0;
    assign ack1      = r_ack1;
    assign busy      = r_busy;
    assign grant_id  = r_grant;
    assign out_valid = r_valid;
    assign out_cat   = r_cat;
    assign out_rep   = r_rep;
    assign out_shl   = r_shl;

endmodule

// File: tb/tb_operadores_seq_arb.sv
module tb_operadores_seq_arb;

    localparam int W  = 6;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req0, req1;
    logic [W-1:0]    dataa0, datab0, dataa1, datab1;
    logic [SW-1:0]   shamt0, shamt1;
    logic            ack0, ack1, busy, grant_id, out_valid;
    logic [W-1:0]    out_cat, out_shl;
    logic [3*W-1:0]  out_rep;

    always #5 clk = ~clk;

    operadores_seq_arb #(.W(W), .SW(SW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .dataa0(dataa0), .datab0(datab0), .shamt0(shamt0), .ack0(ack0),
        .req1(req1), .dataa1(dataa1), .datab1(datab1), .shamt1(shamt1), .ack1(ack1),
        .busy(busy), .grant_id(grant_id), .out_valid(out_valid),
        .out_cat(out_cat), .out_rep(out_rep), .out_shl(out_shl)
    );

    typedef struct {
        logic          ch;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [SW-1:0] sh;
        logic [W-1:0]  cat;
        logic [W-1:0]  shl;
    } vec_t;

    typedef struct {
        logic          gnt;
        logic [W-1:0]  cat;
        logic [W-1:0]  shl;
        int            vcyc;
    } exp_t;

    exp_t sbq[$];
    exp_t m_e;
    int   cyc = 0;
    int   n_err = 0;
    int   n_chk = 0;
    int   n_ack0 = 0;
    int   n_ack1 = 0;
    int   n_val = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard monitor: every strobe must match the oldest pending expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (ack0) n_ack0++;
                if (ack1) n_ack1++;
                if (out_valid) begin
                    n_val++;
                    if (sbq.size() == 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_valid: out_valid=1 with no pending job (cycle %0d)", cyc);
                    end else begin
                        m_e = sbq.pop_front();
                        chk("grant_id", {31'd0, grant_id}, {31'd0, m_e.gnt});
                        chk("out_cat", {26'd0, out_cat}, {26'd0, m_e.cat});
                        chk("out_rep", {14'd0, out_rep}, {14'd0, {3{m_e.cat}}});
                        chk("out_shl", {26'd0, out_shl}, {26'd0, m_e.shl});
                        chk("valid_cycle", cyc, m_e.vcyc);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (busy && k < 40) begin
            step();
            k++;
        end
        if (busy) begin
            n_chk++;
            n_err++;
            $display("FAIL %s: busy still high after %0d cycles", name, k);
        end
    endtask

    // One isolated request; called at negedge+1 with the DUT idle.
    task automatic run_op(input logic ch, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [SW-1:0] sh, input logic [W-1:0] cat, input logic [W-1:0] shl);
        int t0;
        int k;
        if (ch) begin req1 = 1'b1; dataa1 = a; datab1 = b; shamt1 = sh; end
        else    begin req0 = 1'b1; dataa0 = a; datab0 = b; shamt0 = sh; end
        t0 = cyc + 1;
        sbq.push_back('{ch, cat, shl, t0 + 1 + int'(sh)});
        step();
        k = 1;
        while (!(ch ? ack1 : ack0) && k < 20) begin
            step();
            k++;
        end
        chk("ack_cycle", k, 1);
        chk("busy_at_ack", {31'd0, busy}, 32'd1);
        chk("other_ack", {31'd0, (ch ? ack0 : ack1)}, 32'd0);
        req0 = 1'b0;
        req1 = 1'b0;
        // Operands changing after ack must not disturb the running job.
        dataa0 = W'($urandom); datab0 = W'($urandom); shamt0 = SW'($urandom);
        dataa1 = W'($urandom); datab1 = W'($urandom); shamt1 = SW'($urandom);
        wait_idle("op_done");
        chk("grant_hold", {31'd0, grant_id}, {31'd0, ch});
        chk("cat_hold", {26'd0, out_cat}, {26'd0, cat});
        chk("sb_drained", sbq.size(), 32'd0);
    endtask

    vec_t vt[7];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, a1, v, t, k;

        vt[0] = '{1'b0, 6'b101101, 6'b010011, 3'd2, 6'b101011, 6'b101100};
        vt[1] = '{1'b1, 6'b000111, 6'b111000, 3'd0, 6'b111000, 6'b111000};
        vt[2] = '{1'b0, 6'b111111, 6'b111111, 3'd7, 6'b111111, 6'b000000};
        vt[3] = '{1'b0, 6'b110001, 6'b100110, 3'd3, 6'b001110, 6'b110000};
        vt[4] = '{1'b0, 6'b000001, 6'b000001, 3'd5, 6'b001001, 6'b100000};
        vt[5] = '{1'b1, 6'b010010, 6'b001101, 3'd1, 6'b010101, 6'b101010};
        vt[6] = '{1'b1, 6'b000100, 6'b000011, 3'd6, 6'b100011, 6'b000000};

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        dataa0 = '0; datab0 = '0; shamt0 = '0;
        dataa1 = '0; datab1 = '0; shamt1 = '0;
        step();
        step();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ack", {30'd0, ack1, ack0}, 32'd0);
        chk("rst_grant", {31'd0, grant_id}, 32'd0);
        chk("rst_cat", {26'd0, out_cat}, 32'd0);
        chk("rst_rep", {14'd0, out_rep}, 32'd0);
        chk("rst_shl", {26'd0, out_shl}, 32'd0);

        // Contention from reset: both requests held, grants must alternate 0,1,0,1.
        req0 = 1'b1; dataa0 = 6'b101101; datab0 = 6'b010011; shamt0 = 3'd1;
        req1 = 1'b1; dataa1 = 6'b000111; datab1 = 6'b111000; shamt1 = 3'd0;
        a0 = n_ack0; a1 = n_ack1; v = n_val;
        rst_n = 1'b1;
        t = cyc + 1;
        sbq.push_back('{1'b0, 6'b101011, 6'b010110, t + 2}); t += 4;
        sbq.push_back('{1'b1, 6'b111000, 6'b111000, t + 1}); t += 3;
        sbq.push_back('{1'b0, 6'b101011, 6'b010110, t + 2}); t += 4;
        sbq.push_back('{1'b1, 6'b111000, 6'b111000, t + 1});
        k = 0;
        while ((n_ack0 + n_ack1) < (a0 + a1 + 4) && k < 60) begin
            step();
            k++;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        wait_idle("contend_done");
        step();
        chk("contend_ack0", n_ack0 - a0, 32'd2);
        chk("contend_ack1", n_ack1 - a1, 32'd2);
        chk("contend_valids", n_val - v, 32'd4);
        chk("contend_drained", sbq.size(), 32'd0);

        // Table of isolated operations.
        for (int i = 0; i < 7; i++) begin
            run_op(vt[i].ch, vt[i].a, vt[i].b, vt[i].sh, vt[i].cat, vt[i].shl);
            step();
        end

        // Abort: reset during SHIFT of a shamt=5 job; nothing pushed so any strobe is flagged.
        req0 = 1'b1; dataa0 = 6'b101101; datab0 = 6'b010011; shamt0 = 3'd5;
        k = 0;
        step();
        while (!ack0 && k < 20) begin
            step();
            k++;
        end
        chk("abort_ack", {31'd0, ack0}, 32'd1);
        req0 = 1'b0;
        step();
        step();
        chk("abort_in_shift", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", {31'd0, busy}, 32'd0);
        chk("async_cat", {26'd0, out_cat}, 32'd0);
        chk("async_rep", {14'd0, out_rep}, 32'd0);
        chk("async_shl", {26'd0, out_shl}, 32'd0);
        chk("async_grant", {31'd0, grant_id}, 32'd0);
        step();
        step();
        rst_n = 1'b1;
        v = n_val;
        for (int i = 0; i < 10; i++) step();
        chk("abort_no_valid", n_val - v, 32'd0);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        run_op(1'b0, 6'b101101, 6'b010011, 3'd2, 6'b101011, 6'b101100);
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
